inst_decode_queue: RTL and testbench
====================================

Name: inst_decode_queue

Overview:
- Parametrised instruction pre-decode FIFO between fetch and decode/rename.
- At enqueue, classifies each 32-bit instruction by format (R/R4/I/S/B/U/J/V), extracts register fields and the sign-extended immediate, and resolves the fetch-stage exception cause. Stores the result in a DEPTH-entry circular buffer.
- Generalises the fixed-width type definitions with configurable XLEN, depth, and optional opcode groups (custom OP_BS, vector OP_V, FP).
- Adds valid/ready buffering and flush.

Parameters:
- XLEN, 64, datapath/PC/immediate width (32 or 64).
- DEPTH, 4, FIFO entries; power of two, ≥2.
- EN_BS, 1, OP_BS (7'b0101011) legal when 1, else illegal.
- EN_V, 1, OP_V (7'b1010111) legal when 1, else illegal.
- EN_FP, 1, OP_LOAD_FP/STORE_FP/FP/FMADD/FMSUB/FNMSUB/FNMADD legal when 1.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- flush_i  in  1  discard all entries
- in_valid_i  in  1  fetch offers an instruction
- in_ready_o  out  1  queue can accept
- in_inst_i  in  32  raw instruction
- in_pc_i  in  XLEN  instruction PC
- in_fault_i  in  1  fetch access fault
- out_valid_o  out  1  head entry valid
- out_ready_i  in  1  decode consumes head
- out_pc_o  out  XLEN  head PC
- out_opcode_o  out  7  opcode
- out_fmt_o  out  3  format: 0=R 1=R4 2=I 3=S 4=B 5=U 6=J 7=V
- out_rd_o / out_rs1_o / out_rs2_o / out_rs3_o  out  5 each  inst[11:7] / [19:15] / [24:20] / [31:27]
- out_func3_o  out  3  inst[14:12]
- out_func7_o  out  7  inst[31:25]
- out_imm_o  out  XLEN  sign-extended immediate
- out_ex_valid_o  out  1  head carries an exception
- out_ex_cause_o  out  XLEN  exception cause code
- count_o  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Reset (rst_i asynchronous, active-high):
  - Pointers and count cleared; out_valid_o=0; in_ready_o=1; count_o=0.
  - Storage contents need not be cleared. Head outputs present the stored entry and are don't-care while out_valid_o=0.
- Handshakes:
  - push = in_valid_i & in_ready_o.
  - pop = out_valid_o & out_ready_i.
  - in_ready_o = (count<DEPTH), with no same-cycle pass-through when full.
  - out_valid_o = (count!=0).
- Latency: an instruction pushed in cycle N appears at the head in cycle N+1 at the earliest. There is no combinational in→out path.
- Simultaneous push and pop: count unchanged and both pointers advance. This is legal at any occupancy, including full with pop (in_ready_o is still 0 in that case, so no push occurs).
- Pointers wrap modulo DEPTH. count_o reaches DEPTH exactly when full.
- flush_i has priority over push and pop. Next cycle count=0 and out_valid_o=0; a same-cycle push is dropped. in_ready_o is not gated by flush_i.
- Decode is combinational on the input side; results are registered into the entry.
- Format classification:
  - R: ALU, ALU_W, ATOMICS, FP.
  - R4: FMADD/FMSUB/FNMSUB/FNMADD.
  - I: LOAD, LOAD_FP, ALU_I, ALU_I_W, JALR, FENCE, SYSTEM, BS.
  - S: STORE, STORE_FP.
  - B: BRANCH.
  - U: LUI, AUIPC.
  - J: JAL.
  - V: OP_V.
- Immediate per format (all sign-extended from inst[31] to XLEN):
  - I: inst[31:20].
  - S: {inst[31:25],inst[11:7]}.
  - B: {inst[31],inst[7],inst[30:25],inst[11:8],1'b0}.
  - U: {inst[31:12],12'b0}.
  - J: {inst[31],inst[19:12],inst[20],inst[30:21],1'b0}.
  - R/R4/V: imm=0.
- Exception cause, first match wins:
  - in_pc_i[1:0]!=0 → INSTR_ADDR_MISALIGNED (0x00).
  - in_fault_i → INSTR_ACCESS_FAULT (0x01).
  - inst[1:0]!=2'b11, opcode not in the enumerated set, or an opcode group disabled by parameter → ILLEGAL_INSTR (0x02).
  - Otherwise cause=NONE (0xFF) and ex_valid=0.
  - For exception entries, the field outputs are still the raw extraction; only ex_valid/cause are authoritative.
- When XLEN=32, cause codes are truncated to 32 bits (NONE=0x000000FF).

Decomposition:
- Existing shared package (extended, not copied): the opcode enum, exception cause enum, and instruction_t union.
- Add a format-class enum inst_fmt_t (3-bit, values above) to that package.
- Sub-module inst_predecode: purely combinational, instruction+pc+fault → entry struct. Instantiated once by inst_decode_queue, which owns the FIFO.

Test Plan:
- Reset then push ADDI x1,x0,-1 (0xFFF00093) at pc 0x80000000 → next cycle out_valid_o=1, fmt=2, rd=1, imm=0xFFFFFFFFFFFFFFFF, ex_valid_o=0, cause=0xFF.
- Push 5 instructions with out_ready_i=0 → in_ready_o=0 after the 4th; count_o=4; 5th not accepted. Draining returns PCs 0,4,8,12 in order.
- At count=2, push and pop in the same cycle for 8 cycles → count_o stays 2; pointers wrap; order preserved.
- Push BEQ encoding 0x00000463 (imm=8) → fmt=4, imm=8. Push JAL 0xFFDFF0EF → fmt=6, imm=-4 (0x...FFFC), rd=1.
- Priority/illegal: pc=0x2 with in_fault_i=1 → cause 0x00. pc=0x4, in_fault_i=1 → cause 0x01. inst 0x0000002B with EN_BS=0 → cause 0x02. inst 0x00000000 → cause 0x02.
- At count=3, assert flush_i together with in_valid_i → next cycle count_o=0, out_valid_o=0, pushed instruction absent. Reset asserted mid-stream → out_valid_o drops immediately (asynchronous).

Source files
------------

// File: rtl/inst_decode_queue_pkg.sv
// Shared instruction encodings for the fetch/decode boundary: opcodes, exception
// causes, format classes, raw-instruction views and the pre-decoded queue entry.
package inst_decode_queue_pkg;

  typedef enum logic [6:0] {
    OP_LOAD     = 7'b0000011,
    OP_LOAD_FP  = 7'b0000111,
    OP_FENCE    = 7'b0001111,
    OP_ALU_I    = 7'b0010011,
    OP_AUIPC    = 7'b0010111,
    OP_ALU_I_W  = 7'b0011011,
    OP_STORE    = 7'b0100011,
    OP_STORE_FP = 7'b0100111,
    OP_BS       = 7'b0101011,
    OP_ATOMICS  = 7'b0101111,
    OP_ALU      = 7'b0110011,
    OP_LUI      = 7'b0110111,
    OP_ALU_W    = 7'b0111011,
    OP_FMADD    = 7'b1000011,
    OP_FMSUB    = 7'b1000111,
    OP_FNMSUB   = 7'b1001011,
    OP_FNMADD   = 7'b1001111,
    OP_FP       = 7'b1010011,
    OP_V        = 7'b1010111,
    OP_BRANCH   = 7'b1100011,
    OP_JALR     = 7'b1100111,
    OP_JAL      = 7'b1101111,
    OP_SYSTEM   = 7'b1110011
  } opcode_t;

  typedef enum logic [7:0] {
    INSTR_ADDR_MISALIGNED = 8'h00,
    INSTR_ACCESS_FAULT    = 8'h01,
    ILLEGAL_INSTR         = 8'h02,
    CAUSE_NONE            = 8'hFF
  } ex_cause_t;

  typedef enum logic [2:0] {
    FMT_R  = 3'd0,
    FMT_R4 = 3'd1,
    FMT_I  = 3'd2,
    FMT_S  = 3'd3,
    FMT_B  = 3'd4,
    FMT_U  = 3'd5,
    FMT_J  = 3'd6,
    FMT_V  = 3'd7
  } inst_fmt_t;

  typedef struct packed {
    logic [6:0] func7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] func3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } r_type_t;

  typedef struct packed {
    logic [4:0] rs3;
    logic [1:0] funct2;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] func3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } r4_type_t;

  typedef struct packed {
    logic [11:0] imm;
    logic [4:0]  rs1;
    logic [2:0]  func3;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } i_type_t;

  typedef struct packed {
    logic [6:0] imm_hi;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] func3;
    logic [4:0] imm_lo;
    logic [6:0] opcode;
  } s_type_t;

  typedef struct packed {
    logic [19:0] imm;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } u_type_t;

  typedef union packed {
    r_type_t     r;
    r4_type_t    r4;
    i_type_t     i;
    s_type_t     s;
    u_type_t     u;
    logic [31:0] raw;
  } instruction_t;

  // Immediate is held at the widest XLEN; narrower builds take the low bits.
  typedef struct packed {
    logic [6:0]  opcode;
    inst_fmt_t   fmt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rs3;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [63:0] imm;
    logic        ex_valid;
    ex_cause_t   cause;
  } entry_t;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/inst_predecode.sv
// Combinational pre-decode of one raw instruction into a queue entry.
// Zero latency, no state, no flow control.
module inst_predecode
  import inst_decode_queue_pkg::*;
#(
  parameter bit EN_BS = 1'b1,
  parameter bit EN_V  = 1'b1,
  parameter bit EN_FP = 1'b1
) (
  input  logic [31:0] inst_i,
  input  logic [1:0]  pc_lo_i,
  input  logic        fault_i,
  output entry_t      entry_o
);

  instruction_t ins;
  inst_fmt_t    fmt;
  logic         legal;
  logic [31:0]  imm_i, imm_s, imm_b, imm_u, imm_j, imm32;

  assign ins = inst_i;

  assign imm_i = {{20{inst_i[31]}}, ins.i.imm};
  assign imm_s = {{20{inst_i[31]}}, ins.s.imm_hi, ins.s.imm_lo};
  assign imm_b = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_u = {ins.u.imm, 12'b0};
  assign imm_j = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

  always_comb begin
    fmt   = FMT_R;
    legal = 1'b1;
    case (ins.r.opcode)
      OP_ALU, OP_ALU_W, OP_ATOMICS:            fmt = FMT_R;
      OP_FP:                                   begin fmt = FMT_R;  legal = EN_FP; end
      OP_FMADD, OP_FMSUB, OP_FNMSUB, OP_FNMADD: begin fmt = FMT_R4; legal = EN_FP; end
      OP_LOAD, OP_ALU_I, OP_ALU_I_W, OP_JALR, OP_FENCE, OP_SYSTEM: fmt = FMT_I;
      OP_LOAD_FP:                              begin fmt = FMT_I;  legal = EN_FP; end
      OP_BS:                                   begin fmt = FMT_I;  legal = EN_BS; end
      OP_STORE:                                fmt = FMT_S;
      OP_STORE_FP:                             begin fmt = FMT_S;  legal = EN_FP; end
      OP_BRANCH:                               fmt = FMT_B;
      OP_LUI, OP_AUIPC:                        fmt = FMT_U;
      OP_JAL:                                  fmt = FMT_J;
      OP_V:                                    begin fmt = FMT_V;  legal = EN_V; end
      default:                                 legal = 1'b0;
    endcase
  end

  always_comb begin
    case (fmt)
      FMT_I:   imm32 = imm_i;
      FMT_S:   imm32 = imm_s;
      FMT_B:   imm32 = imm_b;
      FMT_U:   imm32 = imm_u;
      FMT_J:   imm32 = imm_j;
      default: imm32 = 32'd0;
    endcase
  end

  always_comb begin
    entry_o.opcode = ins.r.opcode;
    entry_o.fmt    = fmt;
    entry_o.rd     = ins.r.rd;
    entry_o.rs1    = ins.r.rs1;
    entry_o.rs2    = ins.r.rs2;
    entry_o.rs3    = ins.r4.rs3;
    entry_o.func3  = ins.r.func3;
    entry_o.func7  = ins.r.func7;
    entry_o.imm    = sext32(imm32);
    // Fetch-side faults outrank decode legality.
    if (pc_lo_i != 2'b00)
      entry_o.cause = INSTR_ADDR_MISALIGNED;
    else if (fault_i)
      entry_o.cause = INSTR_ACCESS_FAULT;
    else if ((inst_i[1:0] != 2'b11) || !legal)
      entry_o.cause = ILLEGAL_INSTR;
    else
      entry_o.cause = CAUSE_NONE;
    entry_o.ex_valid = (entry_o.cause != CAUSE_NONE);
  end

endmodule

// File: rtl/inst_decode_queue.sv
// Pre-decoding FIFO between fetch and decode; push to head visibility is one cycle.
// in_ready_o drops when full (no pass-through); flush empties the queue next cycle.
module inst_decode_queue
  import inst_decode_queue_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4,
  parameter bit EN_BS = 1'b1,
  parameter bit EN_V  = 1'b1,
  parameter bit EN_FP = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [31:0]                in_inst_i,
  input  logic [XLEN-1:0]            in_pc_i,
  input  logic                       in_fault_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [XLEN-1:0]            out_pc_o,
  output logic [6:0]                 out_opcode_o,
  output logic [2:0]                 out_fmt_o,
  output logic [4:0]                 out_rd_o,
  output logic [4:0]                 out_rs1_o,
  output logic [4:0]                 out_rs2_o,
  output logic [4:0]                 out_rs3_o,
  output logic [2:0]                 out_func3_o,
  output logic [6:0]                 out_func7_o,
  output logic [XLEN-1:0]            out_imm_o,
  output logic                       out_ex_valid_o,
  output logic [XLEN-1:0]            out_ex_cause_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  entry_t          mem    [DEPTH];
  logic [XLEN-1:0] pc_mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  entry_t          new_entry, head;
  logic            push, pop;

  inst_predecode #(.EN_BS(EN_BS), .EN_V(EN_V), .EN_FP(EN_FP)) u_predecode (
    .inst_i  (in_inst_i),
    .pc_lo_i (in_pc_i[1:0]),
    .fault_i (in_fault_i),
    .entry_o (new_entry)
  );

  assign in_ready_o  = (count < FULL_CNT);
  assign out_valid_o = (count != '0);
  assign push        = in_valid_i & in_ready_o & ~flush_i;
  assign pop         = out_valid_o & out_ready_i & ~flush_i;
  assign count_o     = count;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Payload storage carries no reset; validity lives entirely in count.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr]    <= new_entry;
      pc_mem[wr_ptr] <= in_pc_i;
    end
  end

  assign head           = mem[rd_ptr];
  assign out_pc_o       = pc_mem[rd_ptr];
  assign out_opcode_o   = head.opcode;
  assign out_fmt_o      = head.fmt;
  assign out_rd_o       = head.rd;
  assign out_rs1_o      = head.rs1;
  assign out_rs2_o      = head.rs2;
  assign out_rs3_o      = head.rs3;
  assign out_func3_o    = head.func3;
  assign out_func7_o    = head.func7;
  assign out_imm_o      = head.imm[XLEN-1:0];
  assign out_ex_valid_o = head.ex_valid;
  assign out_ex_cause_o = {{(XLEN-8){1'b0}}, head.cause};

endmodule

// File: tb/tb_inst_decode_queue.sv
// Directed bench for inst_decode_queue (XLEN=64, DEPTH=4, BS opcode group disabled).
module tb_inst_decode_queue;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, in_fault, out_valid, out_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc, out_pc, out_imm, out_ex_cause;
  logic [6:0]  out_opcode, out_func7;
  logic [2:0]  out_fmt, out_func3, count;
  logic [4:0]  out_rd, out_rs1, out_rs2, out_rs3;
  logic        out_ex_valid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  inst_decode_queue #(.XLEN(64), .DEPTH(4), .EN_BS(1'b0), .EN_V(1'b1), .EN_FP(1'b1)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .flush_i        (flush),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .in_inst_i      (in_inst),
    .in_pc_i        (in_pc),
    .in_fault_i     (in_fault),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_pc_o       (out_pc),
    .out_opcode_o   (out_opcode),
    .out_fmt_o      (out_fmt),
    .out_rd_o       (out_rd),
    .out_rs1_o      (out_rs1),
    .out_rs2_o      (out_rs2),
    .out_rs3_o      (out_rs3),
    .out_func3_o    (out_func3),
    .out_func7_o    (out_func7),
    .out_imm_o      (out_imm),
    .out_ex_valid_o (out_ex_valid),
    .out_ex_cause_o (out_ex_cause),
    .count_o        (count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Push one instruction into an empty queue, leave it at the head for checking.
  task automatic push1(input logic [31:0] inst, input logic [63:0] pc, input logic fault);
    in_valid = 1'b1; in_inst = inst; in_pc = pc; in_fault = fault;
    cyc();
    in_valid = 1'b0; in_fault = 1'b0;
  endtask

  task automatic pop1();
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = 32'h0; in_pc = 64'h0; in_fault = 1'b0;
    #12;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
    chk("rst_count",     {61'd0, count},     64'd0);
    cyc();
    rst = 1'b0;
    cyc();

    // ADDI x1,x0,-1
    push1(32'hFFF00093, 64'h8000_0000, 1'b0);
    chk("addi_valid", {63'd0, out_valid}, 64'd1);
    chk("addi_pc",    out_pc, 64'h8000_0000);
    chk("addi_fmt",   {61'd0, out_fmt}, 64'd2);
    chk("addi_rd",    {59'd0, out_rd}, 64'd1);
    chk("addi_imm",   out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi_ex",    {63'd0, out_ex_valid}, 64'd0);
    chk("addi_cause", out_ex_cause, 64'hFF);
    pop1();
    chk("addi_drained", {61'd0, count}, 64'd0);

    // Fill past capacity with no consumer.
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("fill_rdy%0d", i), {63'd0, in_ready}, (i < 4) ? 64'd1 : 64'd0);
      in_valid = 1'b1; in_inst = 32'h00000013; in_pc = 64'(i * 4);
      cyc();
    end
    in_valid = 1'b0;
    chk("full_count", {61'd0, count}, 64'd4);
    chk("full_ready", {63'd0, in_ready}, 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_pc%0d", i), out_pc, 64'(i * 4));
      cyc();
    end
    out_ready = 1'b0;
    chk("drain_empty", {63'd0, out_valid}, 64'd0);

    // Steady push+pop at occupancy 2 across pointer wrap.
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_inst = 32'h00000013; in_pc = 64'h100 + 64'(i * 4);
      cyc();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_pc = 64'h108 + 64'(k * 4);
      chk($sformatf("pp_pc%0d", k), out_pc, 64'h100 + 64'(k * 4));
      chk($sformatf("pp_cnt%0d", k), {61'd0, count}, 64'd2);
      cyc();
    end
    in_valid = 1'b0;
    chk("pp_cnt_end", {61'd0, count}, 64'd2);
    chk("pp_tail0", out_pc, 64'h120);
    cyc();
    chk("pp_tail1", out_pc, 64'h124);
    cyc();
    out_ready = 1'b0;
    chk("pp_empty", {61'd0, count}, 64'd0);

    push1(32'h00000463, 64'h200, 1'b0);   // BEQ +8
    chk("beq_fmt", {61'd0, out_fmt}, 64'd4);
    chk("beq_imm", out_imm, 64'd8);
    pop1();
    push1(32'hFFDFF0EF, 64'h204, 1'b0);   // JAL x1,-4
    chk("jal_fmt", {61'd0, out_fmt}, 64'd6);
    chk("jal_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("jal_rd",  {59'd0, out_rd}, 64'd1);
    pop1();
    push1(32'h0020A423, 64'h208, 1'b0);   // SW x2,8(x1)
    chk("sw_fmt",  {61'd0, out_fmt}, 64'd3);
    chk("sw_imm",  out_imm, 64'd8);
    chk("sw_rs1",  {59'd0, out_rs1}, 64'd1);
    chk("sw_rs2",  {59'd0, out_rs2}, 64'd2);
    chk("sw_f3",   {61'd0, out_func3}, 64'd2);
    pop1();
    push1(32'h123450B7, 64'h20C, 1'b0);   // LUI x1,0x12345
    chk("lui_fmt", {61'd0, out_fmt}, 64'd5);
    chk("lui_imm", out_imm, 64'h1234_5000);
    pop1();
    push1(32'h00000057, 64'h210, 1'b0);   // vector op, enabled
    chk("v_fmt",   {61'd0, out_fmt}, 64'd7);
    chk("v_cause", out_ex_cause, 64'hFF);
    pop1();

    // Exception priority and illegal encodings.
    push1(32'h00000013, 64'h2, 1'b1);
    chk("mis_ex",    {63'd0, out_ex_valid}, 64'd1);
    chk("mis_cause", out_ex_cause, 64'h00);
    pop1();
    push1(32'h00000013, 64'h4, 1'b1);
    chk("acc_cause", out_ex_cause, 64'h01);
    pop1();
    push1(32'h0000002B, 64'h8, 1'b0);
    chk("bs_ex",     {63'd0, out_ex_valid}, 64'd1);
    chk("bs_cause",  out_ex_cause, 64'h02);
    pop1();
    push1(32'h00000000, 64'hC, 1'b0);
    chk("zero_cause", out_ex_cause, 64'h02);
    pop1();

    // Flush at occupancy 3 with a concurrent push.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_inst = 32'h00000013; in_pc = 64'h300 + 64'(i * 4);
      cyc();
    end
    chk("pre_flush_cnt", {61'd0, count}, 64'd3);
    flush = 1'b1; in_pc = 64'h3F0;
    chk("flush_rdy", {63'd0, in_ready}, 64'd1);
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_cnt",   {61'd0, count}, 64'd0);
    chk("flush_valid", {63'd0, out_valid}, 64'd0);
    push1(32'h00000013, 64'h400, 1'b0);
    chk("post_flush_pc",  out_pc, 64'h400);
    chk("post_flush_cnt", {61'd0, count}, 64'd1);

    // Asynchronous reset between clock edges.
    push1(32'h00000013, 64'h404, 1'b0);
    chk("pre_rst_cnt", {61'd0, count}, 64'd2);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_cnt",   {61'd0, count}, 64'd0);
    cyc();
    rst = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
